// File: rtl/rc_pkg.sv
// Shared types and defaults for the ripple counter sampler.
// Used by the synchronizer and the sampler top.
package rc_pkg;

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        SETTLE
    } rc_state_t;

    localparam int RC_WIDTH         = 4;
    localparam int RC_STABLE_CYCLES = 3;

endpackage

// File: rtl/bus_sync.sv
// Two-flop per-bit synchronizer for the ripple count bus.
// Bits cross independently; the filter downstream restores coherence.
module bus_sync
    import rc_pkg::*;
#(
    parameter int WIDTH = RC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    assign dout = s2;

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples an async ripple count, filters transients, and
// publishes settled changes as one-entry valid/ready events.
module ripple_count_sampler
    import rc_pkg::*;
#(
    parameter int WIDTH         = RC_WIDTH,
    parameter int STABLE_CYCLES = RC_STABLE_CYCLES,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_async,
    output logic [WIDTH-1:0]  stable_count,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [WIDTH-1:0]  evt_count,
    output logic              evt_wrap,
    output logic [WRAP_W-1:0] wrap_total,
    output logic              overrun,
    input  logic              clear_overrun
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] SC_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] SC_ACC = SW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [SW-1:0]    stab_cnt;
    rc_state_t        state;
    rc_state_t        state_d;
    logic             accept;
    logic             take;
    logic             load;
    logic             load_wrap;

    bus_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (count_async),
        .dout  (s2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (s2 != cand) begin
            cand     <= s2;
            stab_cnt <= SW'(1);
        end else if (stab_cnt != SC_MAX) begin
            stab_cnt <= stab_cnt + SW'(1);
        end
    end

    assign accept    = (s2 == cand) && (stab_cnt == SC_ACC);
    assign load_wrap = cand < stable_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQUIRE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        take    = 1'b0;
        load    = 1'b0;
        case (state)
            ACQUIRE: begin
                if (accept) begin
                    take    = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (s2 != stable_count) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (accept) begin
                    state_d = TRACK;
                    if (cand != stable_count) begin
                        take = 1'b1;
                        load = 1'b1;
                    end
                end
            end
            default: state_d = ACQUIRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_count <= '0;
            evt_valid    <= 1'b0;
            evt_count    <= '0;
            evt_wrap     <= 1'b0;
            wrap_total   <= '0;
            overrun      <= 1'b0;
        end else begin
            if (take) begin
                stable_count <= cand;
            end
            if (load) begin
                evt_valid <= 1'b1;
                evt_count <= cand;
                evt_wrap  <= load_wrap;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (load && load_wrap && (wrap_total != '1)) begin
                wrap_total <= wrap_total + WRAP_W'(1);
            end
            // A fresh overwrite must not be hidden by a same-cycle clear
            if (load && evt_valid && !evt_ready) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
